gmsk_burst_sequencer: RTL and testbench
=======================================

# gmsk_burst_sequencer

Sequencer and timing master for the GMSK modulator. It generates the sample and symbol strobes from the system clock, frames one GSM-style burst as head tail, payload, end tail and guard, and presents one modulator input bit per symbol. Payload bits arrive through a valid/ready handshake from the burst assembler. The block sits directly upstream of `gmsk_tx` and drives its `symbol_strobe`, `sample_strobe` and `input_bit` inputs.

## Interface
- `CLOCKS_PER_SAMPLE`, default 3: clocks per modulator sample (13 MHz / 3 / 16 = 270.833 ksym/s); must be ≥2.
- `SAMPLES_PER_SYMBOL`, default 16: samples per symbol; must equal the modulator ROM depth.
- `TAIL_SYMBOLS`, default 3: tail symbols at each end of the burst; tail bits are 0.
- `PAYLOAD_SYMBOLS`, default 142: payload symbols per burst, training sequence included.
- `GUARD_SYMBOLS`, default 8: guard symbols after the end tail; guard bits are 0.

Ports:
- `clock`  in  1  single clock; every register is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `burst_start`  in  1  one-cycle request; accepted only in IDLE.
- `data_in`  in  1  payload bit.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  holding register is empty and state is HEAD or PAYLOAD.
- `sample_strobe`  out  1  one-cycle pulse per sample.
- `symbol_strobe`  out  1  one-cycle pulse at the start of each symbol.
- `tx_bit`  out  1  modulator input bit.
- `busy`  out  1  a burst is in progress.
- `burst_done`  out  1  one-cycle pulse at the end of the burst.
- `underrun`  out  1  sticky flag: a payload bit was missing; cleared when a burst is accepted.

## Operation
- States: IDLE → HEAD → PAYLOAD → TAIL → GUARD → IDLE.
- Each state lasts its parameter count of symbols: TAIL_SYMBOLS for HEAD and TAIL, PAYLOAD_SYMBOLS for PAYLOAD, GUARD_SYMBOLS for GUARD.
- Counters: clock divider `div` runs 0..CPS-1, sample counter `scnt` runs 0..SPS-1, and a symbol counter runs within each state. All three are held at 0 in IDLE.
- `sample_strobe` = busy && div==CPS-1.
- `symbol_strobe` = sample_strobe && scnt==0. The two strobes are coincident in that cycle.
- State advances on the symbol_strobe that begins the first symbol of the next state. `tx_bit` updates in that same cycle and holds for the whole symbol.
- `tx_bit` source by state:
  - HEAD, TAIL, GUARD: 0.
  - PAYLOAD: the holding register, which is consumed on each PAYLOAD symbol_strobe.
- Holding register (1 bit plus full flag):
  - Loads on data_valid && data_ready.
  - A load and a consume in the same cycle are legal; the register stays full with the new bit.
  - Loading is enabled from HEAD onward so the first payload bit can be prefetched.
- Underrun: on a PAYLOAD symbol_strobe with the holding register empty, `tx_bit` = 0, `underrun` is set, and the burst continues at full length.
- `burst_done` pulses on the final sample_strobe of the last GUARD symbol; the next cycle is IDLE with busy=0.
- `burst_start` while busy, including the `burst_done` cycle, is ignored.
- Residual holding-register contents are discarded on entry to IDLE.

## Timing
- All outputs reset to 0; state resets to IDLE and the holding register to empty.
- `burst_start` accepted at edge t:
  - busy=1 from t+1.
  - First symbol_strobe at t+CPS, with tx_bit=0 (HEAD).
- Symbol period is CPS×SPS clocks (48 at default parameters).
- Burst length is (2·TAIL+PAYLOAD+GUARD)·CPS·SPS clocks (7488 at default parameters), measured from the first busy cycle to the burst_done cycle inclusive.
- `data_ready` is registered and deasserts the cycle after a load when no consume occurs.
- `reset_n` low at any time, including mid-burst, returns the block to IDLE and clears all outputs asynchronously. No strobe may glitch on reset deassertion.

## Configuration
- `GMSK_SEQ_DIFF_ENCODE_EN` defined: `tx_bit` = raw ⊕ prev.
  - raw is the state-selected bit.
  - prev is the previous raw bit, preset to 1 when a burst is accepted.
  - Encoding applies to every symbol of the burst, tail and guard symbols included.
- Macro undefined: `tx_bit` = raw bit; no encoder register is built.

## Test plan
- Default parameters; pulse burst_start; data_valid held high with alternating bits → 156 symbol_strobes, 2496 sample_strobes, busy=1 for 7488 cycles, one burst_done, underrun=0, tx_bit equal to the payload sequence in symbols 3..144.
- Check strobe spacing → sample_strobe every 3 clocks; symbol_strobe every 48 clocks, always coincident with a sample_strobe.
- Withhold data_valid for payload symbol 10 → tx_bit=0 for that symbol, underrun=1 and sticky to the end of the burst, burst length unchanged; the next burst_start clears underrun.
- Assert reset_n low at cycle 3000 of a burst → busy, strobes and tx_bit are 0 immediately; after release, a new burst runs to full length.
- burst_start mid-burst and in the burst_done cycle → ignored; burst_start one cycle after burst_done → accepted.
- With `GMSK_SEQ_DIFF_ENCODE_EN`: all-ones payload → tx_bit=1 for the first head symbol, then 0 for the rest of HEAD, 1 at the first payload symbol, 0 for the remaining payload symbols, 1 at the first end-tail symbol, then 0 through the end of GUARD.

Source files
------------

// File: rtl/gmsk_burst_sequencer.sv
// GMSK burst sequencer: sample/symbol strobe generator and burst framer ahead of gmsk_tx.
// Optional macro GMSK_SEQ_DIFF_ENCODE_EN builds the tx_bit encoder (raw xor previous raw).
module gmsk_burst_sequencer #(
    parameter int unsigned CLOCKS_PER_SAMPLE  = 3,
    parameter int unsigned SAMPLES_PER_SYMBOL = 16,
    parameter int unsigned TAIL_SYMBOLS       = 3,
    parameter int unsigned PAYLOAD_SYMBOLS    = 142,
    parameter int unsigned GUARD_SYMBOLS      = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic burst_start,
    input  logic data_in,
    input  logic data_valid,
    output logic data_ready,
    output logic sample_strobe,
    output logic symbol_strobe,
    output logic tx_bit,
    output logic busy,
    output logic burst_done,
    output logic underrun
);

    typedef enum logic [2:0] {StIdle, StHead, StPayload, StTail, StGuard} state_t;

    localparam int unsigned DIV_W   = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;
    localparam int unsigned SCNT_W  = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
    localparam int unsigned MAX_TG  = (TAIL_SYMBOLS > GUARD_SYMBOLS) ? TAIL_SYMBOLS : GUARD_SYMBOLS;
    localparam int unsigned MAX_SYM = (PAYLOAD_SYMBOLS > MAX_TG) ? PAYLOAD_SYMBOLS : MAX_TG;
    localparam int unsigned SYM_W   = $clog2(MAX_SYM + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLOCKS_PER_SAMPLE - 1);
    localparam logic [DIV_W-1:0]  DIV_PRE   = DIV_W'(CLOCKS_PER_SAMPLE - 2);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [SYM_W-1:0]  TAIL_LEN  = SYM_W'(TAIL_SYMBOLS);
    localparam logic [SYM_W-1:0]  PAY_LEN   = SYM_W'(PAYLOAD_SYMBOLS);
    localparam logic [SYM_W-1:0]  GUARD_LEN = SYM_W'(GUARD_SYMBOLS);

    state_t              r_state;
    logic                r_busy;
    logic [DIV_W-1:0]    r_div;
    logic [SCNT_W-1:0]   r_scnt;
    logic [SYM_W-1:0]    r_sym;
    logic                r_hold_bit;
    logic                r_hold_full;
    logic                r_data_ready;
    logic                r_tx_bit;
    logic                r_underrun;

    logic                w_sample_strobe;
    logic                w_symbol_strobe;
    logic                w_pre_symbol;
    logic                w_burst_end;
    logic                w_accept;
    logic                w_load;
    logic                w_consume;
    logic                w_hold_full_d;
    logic                w_raw;
    logic                w_tx_d;
    logic [SYM_W-1:0]    w_state_len;
    state_t              w_next_state;
    state_t              w_sym_state;
    state_t              w_state_d;

    always_comb begin
        w_state_len  = TAIL_LEN;
        w_next_state = r_state;
        unique case (r_state)
            StHead: begin
                w_state_len  = TAIL_LEN;
                w_next_state = StPayload;
            end
            StPayload: begin
                w_state_len  = PAY_LEN;
                w_next_state = StTail;
            end
            StTail: begin
                w_state_len  = TAIL_LEN;
                w_next_state = StGuard;
            end
            StGuard: begin
                w_state_len  = GUARD_LEN;
                w_next_state = StIdle;
            end
            default: ;
        endcase
    end

    assign w_sample_strobe = r_busy && (r_div == DIV_LAST);
    assign w_symbol_strobe = w_sample_strobe && (r_scnt == '0);
    // One clock ahead of each symbol strobe, so tx_bit and state are already new in that cycle.
    assign w_pre_symbol    = r_busy && (r_div == DIV_PRE) && (r_scnt == '0);
    assign w_burst_end     = w_sample_strobe && (r_state == StGuard) && (r_sym == GUARD_LEN)
                             && (r_scnt == SCNT_LAST);
    assign w_accept        = burst_start && (r_state == StIdle);

    // r_sym counts symbols already begun in the current state.
    assign w_sym_state     = (r_sym == w_state_len) ? w_next_state : r_state;
    assign w_state_d       = w_pre_symbol ? w_sym_state : r_state;
    assign w_consume       = w_pre_symbol && (w_sym_state == StPayload);
    assign w_load          = data_valid && r_data_ready;
    assign w_hold_full_d   = w_load || (r_hold_full && !w_consume);
    assign w_raw           = w_consume && r_hold_full && r_hold_bit;

`ifdef GMSK_SEQ_DIFF_ENCODE_EN
    logic r_prev;
    assign w_tx_d = w_raw ^ r_prev;
`else
    assign w_tx_d = w_raw;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_div        <= '0;
            r_scnt       <= '0;
            r_sym        <= '0;
            r_hold_bit   <= 1'b0;
            r_hold_full  <= 1'b0;
            r_data_ready <= 1'b0;
            r_tx_bit     <= 1'b0;
            r_underrun   <= 1'b0;
`ifdef GMSK_SEQ_DIFF_ENCODE_EN
            r_prev       <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state      <= StHead;
            r_busy       <= 1'b1;
            r_div        <= '0;
            r_scnt       <= '0;
            r_sym        <= '0;
            r_hold_full  <= 1'b0;
            r_data_ready <= 1'b1;
            r_tx_bit     <= 1'b0;
            r_underrun   <= 1'b0;
`ifdef GMSK_SEQ_DIFF_ENCODE_EN
            r_prev       <= 1'b1;
`endif
        end else if (r_busy) begin
            if (w_burst_end) begin
                r_state      <= StIdle;
                r_busy       <= 1'b0;
                r_div        <= '0;
                r_scnt       <= '0;
                r_sym        <= '0;
                r_hold_full  <= 1'b0;
                r_data_ready <= 1'b0;
                r_tx_bit     <= 1'b0;
            end else begin
                r_div <= w_sample_strobe ? '0 : r_div + DIV_W'(1);
                if (w_sample_strobe) begin
                    r_scnt <= (r_scnt == SCNT_LAST) ? '0 : r_scnt + SCNT_W'(1);
                end
                if (w_pre_symbol) begin
                    r_state  <= w_sym_state;
                    r_sym    <= (r_sym == w_state_len) ? SYM_W'(1) : r_sym + SYM_W'(1);
                    r_tx_bit <= w_tx_d;
                    if (w_consume && !r_hold_full) begin
                        r_underrun <= 1'b1;
                    end
`ifdef GMSK_SEQ_DIFF_ENCODE_EN
                    r_prev   <= w_raw;
`endif
                end
                if (w_load) begin
                    r_hold_bit <= data_in;
                end
                r_hold_full  <= w_hold_full_d;
                r_data_ready <= !w_hold_full_d
                                && ((w_state_d == StHead) || (w_state_d == StPayload));
            end
        end
    end

    assign data_ready    = r_data_ready;
    assign sample_strobe = w_sample_strobe;
    assign symbol_strobe = w_symbol_strobe;
    assign tx_bit        = r_tx_bit;
    assign busy          = r_busy;
    assign burst_done    = w_burst_end;
    assign underrun      = r_underrun;

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Directed bench for gmsk_burst_sequencer; expected bit sequences come from a small burst model.
module tb_gmsk_burst_sequencer;

    localparam int CPS        = 3;
    localparam int SPS        = 16;
    localparam int TAIL       = 3;
    localparam int PAY        = 142;
    localparam int GUARD      = 8;
    localparam int SYM_CLKS   = CPS * SPS;
    localparam int NSYM       = 2 * TAIL + PAY + GUARD;
    localparam int BURST_CLKS = NSYM * SYM_CLKS;

    logic clock       = 1'b0;
    logic reset_n     = 1'b1;
    logic burst_start = 1'b0;
    logic data_in     = 1'b0;
    logic data_valid  = 1'b0;
    logic data_ready, sample_strobe, symbol_strobe, tx_bit, busy, burst_done, underrun;

    int tests = 0;
    int fails = 0;

    int n_sym, n_samp, n_busy, n_done, done_cyc, first_sym_cyc;
    int space_err, tx_err, hold_err, und_err, ready_err;
    bit timed_out;

    gmsk_burst_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .burst_start   (burst_start),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .sample_strobe (sample_strobe),
        .symbol_strobe (symbol_strobe),
        .tx_bit        (tx_bit),
        .busy          (busy),
        .burst_done    (burst_done),
        .underrun      (underrun)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit reached, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    function automatic bit payload_bit(input bit ones, input int i);
        return ones ? 1'b1 : (i % 2 == 0);
    endfunction

    // Raw (pre-encoder) bit of burst symbol k when source bit `withhold` arrives one symbol late.
    function automatic bit exp_raw(input bit ones, input int withhold, input int k);
        int j;
        if (k < TAIL || k >= TAIL + PAY) return 1'b0;
        j = k - TAIL;
        if (withhold >= 0 && j == withhold) return 1'b0;
        if (withhold >= 0 && j > withhold) j--;
        return payload_bit(ones, j);
    endfunction

    // Called at a negedge; pulses burst_start and follows the burst cycle by cycle.
    task automatic run_burst(input bit ones, input int withhold, input int abort_at,
                             input bit poke);
        int cyc      = 0;
        int hs       = 0;
        int last_ss  = 0;
        int last_sym = 0;
        bit prev_raw = 1'b1;
        bit last_tx  = 1'b0;
        bit raw, exp_bit;
        n_sym = 0; n_samp = 0; n_busy = 0; n_done = 0; done_cyc = 0; first_sym_cyc = 0;
        space_err = 0; tx_err = 0; hold_err = 0; und_err = 0; ready_err = 0; timed_out = 0;
        burst_start = 1'b1;
        data_valid  = 1'b1;
        data_in     = payload_bit(ones, 0);
        forever begin
            @(negedge clock);
            cyc++;
            burst_start = 1'b0;
            if (cyc > BURST_CLKS + 500) begin
                timed_out = 1'b1;
                break;
            end
            if (!busy) break;
            n_busy++;
            if (sample_strobe) begin
                n_samp++;
                if (last_ss != 0 && cyc - last_ss != CPS) space_err++;
                last_ss = cyc;
            end
            if (symbol_strobe) begin
                if (!sample_strobe) space_err++;
                if (last_sym != 0 && cyc - last_sym != SYM_CLKS) space_err++;
                if (n_sym == 0) first_sym_cyc = cyc;
                last_sym = cyc;
                raw      = exp_raw(ones, withhold, n_sym);
`ifdef GMSK_SEQ_DIFF_ENCODE_EN
                exp_bit  = raw ^ prev_raw;
                prev_raw = raw;
`else
                exp_bit  = raw;
`endif
                if (tx_bit !== exp_bit) tx_err++;
                last_tx = exp_bit;
                n_sym++;
            end else if (tx_bit !== last_tx) begin
                hold_err++;
            end
            if (underrun !== (withhold >= 0 && n_sym > TAIL + withhold)) und_err++;
            if (n_sym > TAIL + PAY + 1 && data_ready) ready_err++;
            if (burst_done) begin
                n_done++;
                done_cyc = cyc;
                if (!sample_strobe) space_err++;
                if (poke) burst_start = 1'b1;
            end
            if (poke && cyc == 100) burst_start = 1'b1;
            if (abort_at > 0 && cyc == abort_at) begin
                reset_n = 1'b0;
                break;
            end
            data_valid = !(withhold >= 0 && hs == withhold && n_sym <= TAIL + withhold);
            data_in    = payload_bit(ones, hs);
            if (data_valid && data_ready) hs++;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        tests++;
        if ({busy, sample_strobe, symbol_strobe, tx_bit, burst_done, underrun, data_ready}
            !== 7'b0) begin
            fails++;
            $display("FAIL reset.outputs: got %b, expected 0000000",
                     {busy, sample_strobe, symbol_strobe, tx_bit, burst_done, underrun,
                      data_ready});
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        tests++;
        if ({busy, sample_strobe, symbol_strobe, data_ready} !== 4'b0) begin
            fails++;
            $display("FAIL reset.idle_quiet: got %b, expected 0000",
                     {busy, sample_strobe, symbol_strobe, data_ready});
        end
    endtask

    task automatic test_full_burst();
        run_burst(1'b0, -1, 0, 1'b0);
        tests++;
        if (timed_out !== 1'b0) begin fails++; $display("FAIL full.timeout: got 1, expected 0"); end
        tests++;
        if (n_sym !== NSYM) begin
            fails++; $display("FAIL full.symbols: got %0d, expected %0d", n_sym, NSYM);
        end
        tests++;
        if (n_samp !== NSYM * SPS) begin
            fails++; $display("FAIL full.samples: got %0d, expected %0d", n_samp, NSYM * SPS);
        end
        tests++;
        if (n_busy !== BURST_CLKS) begin
            fails++; $display("FAIL full.busy_cycles: got %0d, expected %0d", n_busy, BURST_CLKS);
        end
        tests++;
        if (n_done !== 1 || done_cyc !== BURST_CLKS) begin
            fails++;
            $display("FAIL full.done: got count %0d at %0d, expected 1 at %0d",
                     n_done, done_cyc, BURST_CLKS);
        end
        tests++;
        if (first_sym_cyc !== CPS) begin
            fails++; $display("FAIL full.first_symbol: got %0d, expected %0d", first_sym_cyc, CPS);
        end
        tests++;
        if (space_err !== 0) begin
            fails++; $display("FAIL full.strobe_spacing: got %0d errors, expected 0", space_err);
        end
        tests++;
        if (tx_err !== 0 || hold_err !== 0) begin
            fails++;
            $display("FAIL full.tx_bit: got %0d symbol and %0d hold errors, expected 0",
                     tx_err, hold_err);
        end
        tests++;
        if (und_err !== 0 || underrun !== 1'b0) begin
            fails++; $display("FAIL full.underrun: got %0d errors, expected 0", und_err);
        end
        tests++;
        if (ready_err !== 0) begin
            fails++; $display("FAIL full.ready_late: got %0d errors, expected 0", ready_err);
        end
    endtask

    task automatic test_underrun();
        run_burst(1'b0, 10, 0, 1'b0);
        tests++;
        if (tx_err !== 0 || hold_err !== 0) begin
            fails++;
            $display("FAIL underrun.tx_bit: got %0d symbol and %0d hold errors, expected 0",
                     tx_err, hold_err);
        end
        tests++;
        if (und_err !== 0) begin
            fails++; $display("FAIL underrun.flag: got %0d errors, expected 0", und_err);
        end
        tests++;
        if (n_busy !== BURST_CLKS || n_sym !== NSYM) begin
            fails++;
            $display("FAIL underrun.length: got %0d cycles %0d symbols, expected %0d %0d",
                     n_busy, n_sym, BURST_CLKS, NSYM);
        end
        tests++;
        if (underrun !== 1'b1) begin
            fails++; $display("FAIL underrun.sticky_idle: got %b, expected 1", underrun);
        end
        run_burst(1'b0, -1, 0, 1'b0);
        tests++;
        if (und_err !== 0 || underrun !== 1'b0) begin
            fails++;
            $display("FAIL underrun.cleared: got %0d errors, final %b, expected 0 errors, 0",
                     und_err, underrun);
        end
    endtask

    task automatic test_reset_mid();
        run_burst(1'b1, -1, 3000, 1'b0);
        tests++;
        if (n_busy !== 3000) begin
            fails++; $display("FAIL reset_mid.reached: got %0d, expected 3000", n_busy);
        end
        #1;
        tests++;
        if ({busy, sample_strobe, symbol_strobe, tx_bit, data_ready, burst_done} !== 6'b0) begin
            fails++;
            $display("FAIL reset_mid.outputs: got %b, expected 000000",
                     {busy, sample_strobe, symbol_strobe, tx_bit, data_ready, burst_done});
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_burst(1'b0, -1, 0, 1'b0);
        tests++;
        if (n_busy !== BURST_CLKS || n_sym !== NSYM || n_done !== 1) begin
            fails++;
            $display("FAIL reset_mid.rerun: got %0d cycles %0d symbols %0d done, expected %0d %0d 1",
                     n_busy, n_sym, n_done, BURST_CLKS, NSYM);
        end
        tests++;
        if (tx_err !== 0 || space_err !== 0) begin
            fails++;
            $display("FAIL reset_mid.rerun_bits: got %0d tx %0d spacing errors, expected 0",
                     tx_err, space_err);
        end
    endtask

    task automatic test_back_to_back();
        run_burst(1'b0, -1, 0, 1'b1);
        tests++;
        if (timed_out !== 1'b0 || n_busy !== BURST_CLKS || n_done !== 1) begin
            fails++;
            $display("FAIL b2b.ignored_starts: got %0d cycles %0d done, expected %0d 1",
                     n_busy, n_done, BURST_CLKS);
        end
        run_burst(1'b1, -1, 0, 1'b0);
        tests++;
        if (n_busy !== BURST_CLKS || first_sym_cyc !== CPS) begin
            fails++;
            $display("FAIL b2b.accepted: got %0d cycles first symbol %0d, expected %0d %0d",
                     n_busy, first_sym_cyc, BURST_CLKS, CPS);
        end
        tests++;
        if (tx_err !== 0 || hold_err !== 0) begin
            fails++;
            $display("FAIL b2b.tx_bit: got %0d symbol and %0d hold errors, expected 0",
                     tx_err, hold_err);
        end
    endtask

`ifdef GMSK_SEQ_DIFF_ENCODE_EN
    task automatic test_diff_encode();
        run_burst(1'b1, -1, 0, 1'b0);
        tests++;
        if (tx_err !== 0 || hold_err !== 0) begin
            fails++;
            $display("FAIL diff.tx_bit: got %0d symbol and %0d hold errors, expected 0",
                     tx_err, hold_err);
        end
        tests++;
        if (n_sym !== NSYM) begin
            fails++; $display("FAIL diff.symbols: got %0d, expected %0d", n_sym, NSYM);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_burst();
        test_underrun();
        test_reset_mid();
        test_back_to_back();
`ifdef GMSK_SEQ_DIFF_ENCODE_EN
        test_diff_encode();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
